iommu_mem_arb: RTL and testbench
================================

# iommu_mem_arb

Round-robin request scheduler that shares the IOMMU's single memory master port (crossbar master `IOMMU_MEM`) among the IOMMU's internal memory requesters: page-table walker, device-context walker, command-queue fetch and fault-queue write. It serialises address-phase requests onto the port, tags each with the requester index as the transaction ID, allows at most one outstanding transaction per requester, and routes responses back by ID. It sits between the IOMMU translation/queue logic and the AXI master adapter feeding the SoC crossbar.

## Interface
- `NumReq`, 4, number of requesters (≥2); index = ID value
- `AddrWidth`, 64, request address width
- `LenWidth`, 8, burst length field width (AXI `len` encoding)
- `IdWidth`, 4, output ID width; must satisfy `$clog2(NumReq) ≤ IdWidth`
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high
- `req_valid_i`  in  NumReq  requester i has a request
- `req_ready_o`  out  NumReq  request i accepted this cycle (one-hot or zero)
- `req_addr_i`  in  NumReq×AddrWidth  request address
- `req_write_i`  in  NumReq  1 = write, 0 = read
- `req_len_i`  in  NumReq×LenWidth  burst length − 1
- `mem_valid_o`  out  1  issued request valid
- `mem_ready_i`  in  1  port accepts request
- `mem_addr_o` / `mem_write_o` / `mem_len_o`  out  AddrWidth / 1 / LenWidth  issued fields
- `mem_id_o`  out  IdWidth  zero-extended requester index
- `rsp_valid_i`  in  1  response beat valid
- `rsp_id_i`  in  IdWidth  response ID
- `rsp_last_i`  in  1  final beat (B response counts as last)
- `rsp_ready_o`  out  1  response beat consumed
- `rsp_valid_o`  out  NumReq  beat routed to requester i
- `rsp_ready_i`  in  NumReq  requester i consumes beat
- `busy_o`  out  NumReq  requester i has an outstanding transaction
- `unexp_rsp_o`  out  1  one-cycle pulse: response ID out of range or not busy

## Operation
- States: IDLE, ISSUE.
- IDLE: eligible set = `req_valid_i & ~busy`. If non-empty, pick first eligible index at or after `rr_ptr` (wrapping mod NumReq); pulse `req_ready_o[i]`; latch addr/write/len/id into output register; set `busy[i]`; `rr_ptr ← (i+1) mod NumReq`; go to ISSUE.
- ISSUE: `mem_valid_o = 1`; output fields held stable. On `mem_ready_i`, go to IDLE.
- Requesters hold valid and fields stable until their ready; arbiter never retracts `mem_valid_o`.
- Response routing: `rsp_valid_o[k] = rsp_valid_i & (rsp_id_i == k) & busy[k]`; `rsp_ready_o = rsp_ready_i[rsp_id_i]` when routed, else 1 (drop).
- On `rsp_valid_i & rsp_ready_o & rsp_last_i` with valid ID and busy set: clear `busy[id]`.
- Unknown/not-busy ID: beat consumed and dropped, `unexp_rsp_o` pulses, no state change.
- Same-cycle grant of i and last-beat completion of j ≠ i: both applied. Completion of i cannot coincide with grant of i (busy blocks eligibility); completion frees i for the next IDLE cycle.

## Timing
- Reset: state IDLE, `rr_ptr` 0, `busy` 0, `mem_valid_o` 0, `mem_addr_o`/`mem_write_o`/`mem_len_o`/`mem_id_o` 0, `req_ready_o` 0, `unexp_rsp_o` 0.
- Grant latency: request visible in IDLE → `req_ready_o` same cycle → `mem_valid_o` next cycle.
- Peak issue rate: one request per 2 cycles (ISSUE→IDLE costs one cycle).
- Response path is combinational (valid/ready pass-through); `busy` updates the cycle after the last-beat handshake.
- Reset mid-ISSUE: request dropped, all busy bits cleared; downstream flushed by the same reset.

## Structure
- `ariane_soc` package: `IOMMUMemNumReq = 4` and enum `iommu_mem_req_t {PTW=0, DDTW=1, CQ=2, FQ=3}`; `IdWidth` taken from there.
- Sub-module `iommu_rr_pick`: combinational rotating-priority picker (eligible mask, pointer → one-hot grant, index, any).

## Test plan
- Single req from CQ (idx 2), addr 0x8000_1000, len 3: ready[2] cycle 0, mem_valid cycle 1, mem_id=2; after 4 beats id 2 last, busy[2] clears.
- All four valid, mem_ready tied 1, immediate responses: grant order 0,1,2,3,0 with rr_ptr wrapping 3→0.
- mem_ready held 0 for 5 cycles: mem_* fields stable, no further req_ready pulses.
- Requester 0 reasserts while busy[0]=1: not granted until its last beat; requester 1 granted meanwhile.
- Response id 3 with busy[3]=0, and id 7: rsp_ready_o=1, no rsp_valid_o, unexp_rsp_o pulses once each.
- Reset asserted during ISSUE with busy=0b0101: next cycle mem_valid_o=0, busy=0, rr_ptr=0.

Source files
------------

// File: rtl/iommu_mem_arb_pkg.sv
// Shared definitions for the IOMMU memory-port arbiter: requester map,
// default widths and the arbiter state encoding.
package iommu_mem_arb_pkg;

  // Number of internal IOMMU memory requesters sharing the master port.
  localparam int unsigned IOMMUMemNumReq    = 4;
  // Transaction ID width presented on the master port.
  localparam int unsigned IOMMUMemIdWidth   = 4;
  localparam int unsigned IOMMUMemAddrWidth = 64;
  localparam int unsigned IOMMUMemLenWidth  = 8;

  // Requester index doubles as the transaction ID.
  typedef enum logic [1:0] {
    PTW  = 2'd0,  // page-table walker
    DDTW = 2'd1,  // device-context walker
    CQ   = 2'd2,  // command-queue fetch
    FQ   = 2'd3   // fault-queue write
  } iommu_mem_req_t;

  // Arbiter states: waiting for a request, or presenting one downstream.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // Width of a requester index / rotating pointer; never zero.
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iommu_rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of the
// eligible mask at or after the pointer, wrapping around the mask width.
module iommu_rr_pick
  import iommu_mem_arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned PtrW = ptr_width(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] idx_o,
  output logic            any_o
);

  // Scan candidates in rotated order; the first eligible one wins.
  // NOTE: every always_comb output gets a default first, so no path leaves a value held and infers a latch.
  always_comb begin
    int unsigned     cand;
    logic [PtrW-1:0] cand_idx;
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand     = (32'(ptr_i) + off) % N;
      cand_idx = PtrW'(cand);
      if (!any_o && eligible_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/iommu_mem_arb.sv
// Round-robin scheduler sharing the IOMMU memory master port among its
// internal requesters. One outstanding transaction per requester, tagged
// with the requester index as ID; responses are routed back by ID.
module iommu_mem_arb
  import iommu_mem_arb_pkg::*;
#(
  parameter int unsigned NumReq    = IOMMUMemNumReq,
  parameter int unsigned AddrWidth = IOMMUMemAddrWidth,
  parameter int unsigned LenWidth  = IOMMUMemLenWidth,
  parameter int unsigned IdWidth   = IOMMUMemIdWidth
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  // requester side
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq-1:0]                  req_write_i,
  input  logic [NumReq-1:0][LenWidth-1:0]    req_len_i,
  // master port, address phase
  output logic                               mem_valid_o,
  input  logic                               mem_ready_i,
  output logic [AddrWidth-1:0]               mem_addr_o,
  output logic                               mem_write_o,
  output logic [LenWidth-1:0]                mem_len_o,
  output logic [IdWidth-1:0]                 mem_id_o,
  // master port, response beats
  input  logic                               rsp_valid_i,
  input  logic [IdWidth-1:0]                 rsp_id_i,
  input  logic                               rsp_last_i,
  output logic                               rsp_ready_o,
  // response fan-out to requesters
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  // status
  output logic [NumReq-1:0]                  busy_o,
  output logic                               unexp_rsp_o
);

  localparam int unsigned PtrW = ptr_width(NumReq);

  arb_state_e state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NumReq-1:0] busy_q, busy_d;

  logic [AddrWidth-1:0] addr_q;
  logic                 write_q;
  logic [LenWidth-1:0]  len_q;
  logic [IdWidth-1:0]   id_q;

  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] pick_grant;
  logic [PtrW-1:0]   pick_idx;
  logic              pick_any;
  logic              grant_en;

  logic [PtrW-1:0]   rsp_idx;
  logic              rsp_in_range;
  logic              rsp_routed;
  logic [NumReq-1:0] rsp_done;

  // A requester already waiting on its response cannot be granted again.
  assign eligible = req_valid_i & ~busy_q;

  iommu_rr_pick #(
    .N (NumReq)
  ) u_pick (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx),
    .any_o      (pick_any)
  );

  // Next-state, grant and pointer advance for the two-state issue FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_en    = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_en = 1'b1;
          state_d  = ISSUE;
          rr_ptr_d = (pick_idx == PtrW'(NumReq - 1)) ? '0 : pick_idx + PtrW'(1);
        end
      end
      ISSUE: begin
        // Once presented, the request stays valid until the port takes it.
        if (mem_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A grant in the reset cycle would be lost, so it is not advertised.
    if (grant_en && !rst_i) begin
      req_ready_o = pick_grant;
    end
  end

  // Route a response beat to its requester, or swallow it if nobody owns the ID.
  always_comb begin
    rsp_idx      = rsp_id_i[PtrW-1:0];
    rsp_in_range = (32'(rsp_id_i) < NumReq);
    rsp_routed   = rsp_valid_i && rsp_in_range && busy_q[rsp_idx];
    rsp_valid_o  = '0;
    rsp_done     = '0;
    rsp_ready_o  = 1'b1;
    if (rsp_routed) begin
      rsp_valid_o[rsp_idx] = 1'b1;
      rsp_ready_o          = rsp_ready_i[rsp_idx];
      if (rsp_ready_i[rsp_idx] && rsp_last_i) begin
        rsp_done[rsp_idx] = 1'b1;
      end
    end
    unexp_rsp_o = rsp_valid_i && !rsp_routed && !rst_i;
  end

  // Outstanding set: add the granted requester, drop the one completing.
  always_comb begin
    busy_d = busy_q & ~rsp_done;
    if (grant_en) begin
      busy_d = busy_d | pick_grant;
    end
  end

  // Control state: FSM, round-robin pointer and outstanding bits.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  // Issued-request register, loaded on grant and held through ISSUE.
  // NOTE: these datapath registers are reset as well because their zero value is visible on the port after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      len_q   <= '0;
      id_q    <= '0;
    end else if (grant_en) begin
      addr_q  <= req_addr_i[pick_idx];
      write_q <= req_write_i[pick_idx];
      len_q   <= req_len_i[pick_idx];
      id_q    <= IdWidth'(pick_idx);
    end
  end

  assign mem_valid_o = (state_q == ISSUE);
  assign mem_addr_o  = addr_q;
  assign mem_write_o = write_q;
  assign mem_len_o   = len_q;
  assign mem_id_o    = id_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_iommu_mem_arb.sv
// Self-checking bench for iommu_mem_arb: a per-cycle reference model with a
// scoreboard of issued requests, a response-routing vector table, and
// directed sequences for round-robin order, stalls and reset mid-issue.
module tb_iommu_mem_arb;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [7:0]  len;
    logic [3:0]  id;
  } sb_t;

  typedef struct {
    logic       rv;
    logic [3:0] id;
    logic       last;
    logic [3:0] rdy;
    logic [3:0] exp_rv;
    logic       exp_rr;
    logic       exp_unexp;
    logic [3:0] exp_busy;
  } rsp_vec_t;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][63:0] req_addr;
  logic [3:0]       req_write;
  logic [3:0][7:0]  req_len;
  logic             mem_valid;
  logic             mem_ready;
  logic [63:0]      mem_addr;
  logic             mem_write;
  logic [7:0]       mem_len;
  logic [3:0]       mem_id;
  logic             rsp_valid;
  logic [3:0]       rsp_id;
  logic             rsp_last;
  logic             rsp_ready_out;
  logic [3:0]       rsp_valid_out;
  logic [3:0]       rsp_ready;
  logic [3:0]       busy;
  logic             unexp;

  // reference model state
  logic       m_issue;
  int         m_ptr;
  logic [3:0] m_busy;
  bit         auto_drop;
  int         hs_id;
  int         cyc;
  sb_t        sb_q[$];
  int         grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iommu_mem_arb dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_len_i   (req_len),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_write_o (mem_write),
    .mem_len_o   (mem_len),
    .mem_id_o    (mem_id),
    .rsp_valid_i (rsp_valid),
    .rsp_id_i    (rsp_id),
    .rsp_last_i  (rsp_last),
    .rsp_ready_o (rsp_ready_out),
    .rsp_valid_o (rsp_valid_out),
    .rsp_ready_i (rsp_ready),
    .busy_o      (busy),
    .unexp_rsp_o (unexp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: called just after a falling edge with inputs driven; checks
  // outputs against the model, advances the model, returns at the next falling edge.
  task automatic tick();
    logic [3:0] elig, exp_grant, exp_rv, set_m, clr_m;
    logic       routed, exp_rr, exp_unexp;
    logic [1:0] rid;
    int         gi;
    #1;
    cyc++;
    gi        = -1;
    exp_grant = '0;
    set_m     = '0;
    clr_m     = '0;
    hs_id     = -1;
    elig      = req_valid & ~m_busy;
    if (!m_issue) begin
      for (int k = 0; k < 4; k++) begin
        if (gi < 0 && elig[2'((m_ptr + k) % 4)]) gi = (m_ptr + k) % 4;
      end
    end
    if (gi >= 0) exp_grant[2'(gi)] = 1'b1;
    rid       = rsp_id[1:0];
    routed    = rsp_valid && (rsp_id < 4'd4) && m_busy[rid];
    exp_rv    = routed ? (4'b0001 << rid) : 4'b0000;
    exp_rr    = routed ? rsp_ready[rid] : 1'b1;
    exp_unexp = rsp_valid && !routed;

    check($sformatf("c%0d req_ready", cyc), 64'(req_ready), 64'(exp_grant));
    check($sformatf("c%0d mem_valid", cyc), 64'(mem_valid), 64'(m_issue));
    check($sformatf("c%0d busy", cyc), 64'(busy), 64'(m_busy));
    check($sformatf("c%0d rsp_valid_o", cyc), 64'(rsp_valid_out), 64'(exp_rv));
    check($sformatf("c%0d rsp_ready_o", cyc), 64'(rsp_ready_out), 64'(exp_rr));
    check($sformatf("c%0d unexp", cyc), 64'(unexp), 64'(exp_unexp));

    if (m_issue) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL c%0d scoreboard: got issued id 0x%0h expected no request", cyc, mem_id);
      end else begin
        check($sformatf("c%0d sb addr", cyc), mem_addr, sb_q[0].addr);
        check($sformatf("c%0d sb write", cyc), 64'(mem_write), 64'(sb_q[0].write));
        check($sformatf("c%0d sb len", cyc), 64'(mem_len), 64'(sb_q[0].len));
        check($sformatf("c%0d sb id", cyc), 64'(mem_id), 64'(sb_q[0].id));
        if (mem_ready) begin
          hs_id = int'(sb_q[0].id);
          void'(sb_q.pop_front());
        end
      end
    end

    for (int k = 0; k < 4; k++) begin
      if (req_ready[2'(k)] === 1'b1) grant_log.push_back(k);
    end

    if (routed && rsp_ready[rid] && rsp_last) clr_m[rid] = 1'b1;
    if (gi >= 0) begin
      set_m[2'(gi)] = 1'b1;
      sb_q.push_back('{addr: req_addr[2'(gi)], write: req_write[2'(gi)],
                       len: req_len[2'(gi)], id: 4'(gi)});
      m_ptr   = (gi + 1) % 4;
      m_issue = 1'b1;
    end else if (m_issue && mem_ready) begin
      m_issue = 1'b0;
    end
    m_busy = (m_busy | set_m) & ~clr_m;

    @(negedge clk);
    if (gi >= 0 && auto_drop) req_valid[2'(gi)] = 1'b0;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    req_valid = '0;
    mem_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_last  = 1'b0;
    rsp_ready = '0;
    @(negedge clk);
    rst_i   = 1'b0;
    m_issue = 1'b0;
    m_ptr   = 0;
    m_busy  = '0;
    sb_q.delete();
    grant_log.delete();
    #1;
    check("rst mem_valid", 64'(mem_valid), 64'd0);
    check("rst mem_addr", mem_addr, 64'd0);
    check("rst mem_write", 64'(mem_write), 64'd0);
    check("rst mem_len", 64'(mem_len), 64'd0);
    check("rst mem_id", 64'(mem_id), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst unexp", 64'(unexp), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_vec_t tbl[10];
    int       exp_order[5];
    int       pending;

    cyc       = 0;
    auto_drop = 1'b1;
    req_addr  = '0;
    req_write = '0;
    req_len   = '0;

    // rv id  last rdy      exp_rv   rr    unexp busy-before
    tbl[0] = '{1'b1, 4'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0101};
    tbl[1] = '{1'b1, 4'd0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0101};
    tbl[2] = '{1'b1, 4'd2, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0101};
    tbl[3] = '{1'b1, 4'd3, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0101};
    tbl[4] = '{1'b1, 4'd7, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0101};
    tbl[5] = '{1'b1, 4'd1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0101};
    tbl[6] = '{1'b0, 4'd2, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0101};
    tbl[7] = '{1'b1, 4'd2, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0101};
    tbl[8] = '{1'b1, 4'd2, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0001};
    tbl[9] = '{1'b1, 4'd0, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001};

    // ---- single CQ request, four response beats ----
    do_reset();
    mem_ready   = 1'b1;
    req_addr[2] = 64'h0000_0000_8000_1000;
    req_len[2]  = 8'd3;
    req_write[2] = 1'b0;
    req_valid   = 4'b0100;
    tick();
    #1;
    check("cq mem_id", 64'(mem_id), 64'd2);
    check("cq mem_addr", mem_addr, 64'h0000_0000_8000_1000);
    check("cq mem_len", 64'(mem_len), 64'd3);
    tick();
    rsp_valid = 1'b1;
    rsp_id    = 4'd2;
    rsp_ready = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      rsp_last = (b == 3);
      tick();
    end
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    #1;
    check("cq busy cleared", 64'(busy), 64'd0);

    // ---- all four requesting, immediate responses: order 0,1,2,3,0 ----
    do_reset();
    auto_drop = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_addr[k]  = 64'h1000 * (k + 1);
      req_len[k]   = 8'(k);
      req_write[k] = k[0];
    end
    req_valid = 4'b1111;
    pending   = -1;
    for (int c = 0; c < 10; c++) begin
      if (pending >= 0) begin
        rsp_valid = 1'b1;
        rsp_id    = 4'(pending);
        rsp_last  = 1'b1;
        rsp_ready = 4'b1111;
      end else begin
        rsp_valid = 1'b0;
      end
      tick();
      pending = hs_id;
    end
    exp_order = '{0, 1, 2, 3, 0};
    check("rr grant count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      check($sformatf("rr grant %0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    end
    auto_drop = 1'b1;

    // ---- port stalled for 5 cycles: fields stable, no further grants ----
    do_reset();
    req_addr[1]  = {$urandom, $urandom};
    req_len[1]   = 8'($urandom_range(0, 255));
    req_write[1] = 1'b1;
    req_addr[3]  = 64'hdead_beef_0000_0040;
    req_len[3]   = 8'd15;
    req_write[3] = 1'b0;
    req_valid    = 4'b0010;
    tick();
    req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) tick();
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    check("stall grant count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("stall grant 0", 64'(grant_log[0]), 64'd1);
      check("stall grant 1", 64'(grant_log[1]), 64'd3);
    end

    // ---- requester 0 re-requests while busy; requester 1 served meanwhile ----
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b0001;
    tick();
    tick();
    req_valid = 4'b0011;
    tick();
    tick();
    tick();
    rsp_valid = 1'b1;
    rsp_id    = 4'd0;
    rsp_last  = 1'b1;
    rsp_ready = 4'b1111;
    tick();
    rsp_valid = 1'b0;
    tick();
    tick();
    check("busy0 grant count", 64'(grant_log.size()), 64'd3);
    if (grant_log.size() == 3) begin
      check("busy0 grant 1", 64'(grant_log[1]), 64'd1);
      check("busy0 grant 2", 64'(grant_log[2]), 64'd0);
    end

    // ---- response-routing table with busy = 0101 ----
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b0101;
    for (int c = 0; c < 4; c++) tick();
    for (int i = 0; i < 10; i++) begin
      rsp_valid = tbl[i].rv;
      rsp_id    = tbl[i].id;
      rsp_last  = tbl[i].last;
      rsp_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d rsp_valid_o", i), 64'(rsp_valid_out), 64'(tbl[i].exp_rv));
      check($sformatf("tbl%0d rsp_ready_o", i), 64'(rsp_ready_out), 64'(tbl[i].exp_rr));
      check($sformatf("tbl%0d unexp", i), 64'(unexp), 64'(tbl[i].exp_unexp));
      check($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].exp_busy));
      tick();
    end
    rsp_valid = 1'b0;
    #1;
    check("tbl final busy", 64'(busy), 64'd0);

    // ---- reset during ISSUE with busy = 0101 ----
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b0101;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    check("pre-rst busy", 64'(busy), 64'b0101);
    check("pre-rst mem_valid", 64'(mem_valid), 64'd1);
    do_reset();
    mem_ready = 1'b1;
    req_valid = 4'b1111;
    tick();
    check("post-rst first grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
